calc_keypad_scanner: RTL and testbench

- Front-end stage of the 16-bit signed calculator. Scans a 4x4 active-low key matrix, synchronises and debounces the column inputs, and decodes each accepted press into one single-cycle event.
- The event is one of: digit (keypad_input + read_input), operator (operator_input code), or equal (equal_input).
- Outputs connect directly to the operand/operator controller.
- One-deep event buffer with a ready handshake, so presses made while the controller is busy in a multiply or ALU wait are not lost.

---
 rtl/calc_keypad_scanner.sv | 258 +++++++++++++++++++++++++
 tb/tb_calc_keypad_scanner.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_keypad_scanner.sv
// calc_keypad_scanner
//   Front end of the 16-bit signed calculator. Drives a 4x4 active-low key
//   matrix one row at a time, synchronises the column inputs, debounces whole
//   scan frames and turns each accepted press into a single-cycle event for
//   the operand/operator controller. A one-deep buffer holds an event until
//   the controller raises ready.
//
//   Optional build macro: KEYPAD_MULTIKEY_REJECT_EN
//     defined   - a frame with more than one key closed counts as "different
//                 key", so chorded presses never produce an event
//     undefined - the lowest-index closed key wins
//
// Ports
//   clk            in   system clock
//   nRST           in   asynchronous active-low reset
//   col_in[3:0]    in   matrix columns, active-low, asynchronous to clk
//   ready          in   controller can take an event this cycle
//   row_out[3:0]   out  row drive, one-cold
//   keypad_input   out  last digit issued (0-9), held between digit events
//   read_input     out  1-cycle digit event
//   operator_input out  1-cycle operator code: 1=NEG 2=ADD 3=SUB 4=MUL
//   equal_input    out  1-cycle equal event
//   key_dropped    out  1-cycle pulse: accepted press lost, buffer was full
module calc_keypad_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       nRST,
  input  logic [3:0] col_in,
  input  logic       ready,
  output logic [3:0] row_out,
  output logic [3:0] keypad_input,
  output logic       read_input,
  output logic [2:0] operator_input,
  output logic       equal_input,
  output logic       key_dropped
);
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CNT);

  localparam logic [1:0] EV_NONE  = 2'd0;
  localparam logic [1:0] EV_DIGIT = 2'd1;
  localparam logic [1:0] EV_OP    = 2'd2;
  localparam logic [1:0] EV_EQUAL = 2'd3;

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;

  logic [3:0]       col_meta_reg, col_sync_reg;
  logic [DIV_W-1:0] div_reg;
  logic [1:0]       row_reg;
  logic [11:0]      keys_acc_reg;
  logic             sample, frame_end;
  logic [15:0]      frame_keys;
  logic [3:0]       key_idx;
  logic             has_key, multi, key_ok;

  state_t           state_reg, state_next;
  logic [3:0]       cand_reg, cand_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
  logic             accept;
  logic [1:0]       ev_kind;
  logic [3:0]       ev_val;

  logic             pend_valid_reg;
  logic [1:0]       pend_kind_reg;
  logic [3:0]       pend_val_reg;
  logic             issue;

  // Two-flop synchroniser; idle level (no key) is all ones.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      col_meta_reg <= 4'hF;
      col_sync_reg <= 4'hF;
    end else begin
      col_meta_reg <= col_in;
      col_sync_reg <= col_meta_reg;
    end
  end

  // Row scan: each row is driven for SCAN_DIV cycles and the columns are
  // sampled in the last cycle of the slot, after the synchroniser settled.
  assign sample    = (div_reg == DIV_LAST);
  assign frame_end = sample && (row_reg == 2'd3);

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      div_reg      <= '0;
      row_reg      <= 2'd0;
      keys_acc_reg <= '0;
    end else if (sample) begin
      div_reg <= '0;
      row_reg <= row_reg + 2'd1;
      case (row_reg)
        2'd0:    keys_acc_reg[3:0]  <= ~col_sync_reg;
        2'd1:    keys_acc_reg[7:4]  <= ~col_sync_reg;
        2'd2:    keys_acc_reg[11:8] <= ~col_sync_reg;
        default: ;
      endcase
    end else begin
      div_reg <= div_reg + DIV_W'(1);
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_row
      assign row_out[gi] = (row_reg != 2'(gi));
    end
  endgenerate

  // Row 3 is not stored: at frame end it is read straight from the synchroniser.
  assign frame_keys = {~col_sync_reg, keys_acc_reg};
  assign has_key    = |frame_keys;
  // x & (x-1) clears the lowest set bit; anything left means a second key.
  assign multi      = |(frame_keys & (frame_keys - 16'd1));

  always_comb begin
    key_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (frame_keys[i]) key_idx = 4'(i);
    end
  end

`ifdef KEYPAD_MULTIKEY_REJECT_EN
  assign key_ok = has_key && !multi;
`else
  assign key_ok = has_key;
`endif

  assign cnt_inc = cnt_reg + CNT_W'(1);

  // Debounce FSM: state register
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_reg <= IDLE;
      cand_reg  <= 4'd0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cand_reg  <= cand_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Debounce FSM: next state, evaluated only at frame end
  always_comb begin
    state_next = state_reg;
    cand_next  = cand_reg;
    cnt_next   = cnt_reg;
    if (frame_end) begin
      case (state_reg)
        IDLE: if (key_ok) begin
          cand_next  = key_idx;
          cnt_next   = CNT_W'(1);
          state_next = (DEBOUNCE_CNT == 1) ? HELD : PRESS_DB;
        end
        PRESS_DB: if (key_ok && key_idx == cand_reg) begin
          cnt_next = cnt_inc;
          if (cnt_inc == CNT_DONE) state_next = HELD;
        end else begin
          cnt_next   = '0;
          state_next = IDLE;
        end
        // Any key, chord included, keeps the press held: no auto-repeat.
        HELD: if (!has_key) begin
          cnt_next   = CNT_W'(1);
          state_next = (DEBOUNCE_CNT == 1) ? IDLE : REL_DB;
        end
        REL_DB: if (!has_key) begin
          cnt_next = cnt_inc;
          if (cnt_inc == CNT_DONE) begin
            cnt_next   = '0;
            state_next = IDLE;
          end
        end else begin
          cnt_next   = '0;
          state_next = HELD;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Debounce FSM: outputs (accept strobe and decode of the accepted key)
  always_comb begin
    accept = 1'b0;
    if (frame_end && key_ok) begin
      if (state_reg == IDLE && DEBOUNCE_CNT == 1) accept = 1'b1;
      if (state_reg == PRESS_DB && key_idx == cand_reg && cnt_inc == CNT_DONE) accept = 1'b1;
    end
    ev_kind = EV_NONE;
    ev_val  = 4'd0;
    case (key_idx)
      4'd0:    begin ev_kind = EV_DIGIT; ev_val = 4'd1; end
      4'd1:    begin ev_kind = EV_DIGIT; ev_val = 4'd2; end
      4'd2:    begin ev_kind = EV_DIGIT; ev_val = 4'd3; end
      4'd3:    begin ev_kind = EV_OP;    ev_val = 4'd2; end
      4'd4:    begin ev_kind = EV_DIGIT; ev_val = 4'd4; end
      4'd5:    begin ev_kind = EV_DIGIT; ev_val = 4'd5; end
      4'd6:    begin ev_kind = EV_DIGIT; ev_val = 4'd6; end
      4'd7:    begin ev_kind = EV_OP;    ev_val = 4'd3; end
      4'd8:    begin ev_kind = EV_DIGIT; ev_val = 4'd7; end
      4'd9:    begin ev_kind = EV_DIGIT; ev_val = 4'd8; end
      4'd10:   begin ev_kind = EV_DIGIT; ev_val = 4'd9; end
      4'd11:   begin ev_kind = EV_OP;    ev_val = 4'd4; end
      4'd12:   begin ev_kind = EV_OP;    ev_val = 4'd1; end
      4'd13:   begin ev_kind = EV_DIGIT; ev_val = 4'd0; end
      4'd14:   begin ev_kind = EV_EQUAL; ev_val = 4'd0; end
      default: ; // spare key: debounced but silent
    endcase
  end

  assign issue = pend_valid_reg && ready;

  // One-deep event buffer and registered event outputs. A slot freed by an
  // issue in the same cycle can take the newly accepted event.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      pend_valid_reg <= 1'b0;
      pend_kind_reg  <= EV_NONE;
      pend_val_reg   <= 4'd0;
      keypad_input   <= 4'd0;
      read_input     <= 1'b0;
      operator_input <= 3'd0;
      equal_input    <= 1'b0;
      key_dropped    <= 1'b0;
    end else begin
      read_input     <= 1'b0;
      operator_input <= 3'd0;
      equal_input    <= 1'b0;
      key_dropped    <= 1'b0;
      if (issue) begin
        case (pend_kind_reg)
          EV_DIGIT: begin
            read_input   <= 1'b1;
            keypad_input <= pend_val_reg;
          end
          EV_OP:    operator_input <= pend_val_reg[2:0];
          EV_EQUAL: equal_input    <= 1'b1;
          default:  ;
        endcase
      end
      if (accept && ev_kind != EV_NONE) begin
        if (!pend_valid_reg || issue) begin
          pend_valid_reg <= 1'b1;
          pend_kind_reg  <= ev_kind;
          pend_val_reg   <= ev_val;
        end else begin
          key_dropped <= 1'b1;
        end
      end else if (issue) begin
        pend_valid_reg <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_calc_keypad_scanner.sv
// Self-checking bench for calc_keypad_scanner (SCAN_DIV=4, DEBOUNCE_CNT=2,
// one frame = 16 clk). A key-matrix model turns a 16-bit mask of closed keys
// into column levels. Key masks change only right after a frame-end edge.
// A frame-level reference model predicts every output on every cycle; a
// per-key table and hand-written sequences check the directed cases.
module tb_calc_keypad_scanner;
  localparam int SD    = 4;
  localparam int DB    = 2;
  localparam int FRAME = 4 * SD;

  logic       clk = 1'b0;
  logic       nRST = 1'b1;
  logic       ready = 1'b0;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic [3:0] keypad_input;
  logic       read_input;
  logic [2:0] operator_input;
  logic       equal_input;
  logic       key_dropped;
  logic [15:0] key_mask = 16'h0;

  calc_keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
    .clk(clk), .nRST(nRST), .col_in(col_in), .ready(ready),
    .row_out(row_out), .keypad_input(keypad_input), .read_input(read_input),
    .operator_input(operator_input), .equal_input(equal_input),
    .key_dropped(key_dropped)
  );

  always #5 clk = ~clk;

  // Key matrix: a closed key on the driven (low) row pulls its column low.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_out[r] && key_mask[4*r+c]) col_in[c] = 1'b0;
  end

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  typedef struct { int kind; int val; } ev_t;    // kind: 0 none, 1 digit, 2 op, 3 equal
  int digit_of [16] = '{1, 2, 3, -1, 4, 5, 6, -1, 7, 8, 9, -1, -1, 0, -1, -1};
  int op_of    [16] = '{0, 0, 0,  2, 0, 0, 0,  3, 0, 0, 0,  4,  1, 0,  0,  0};

  int   edge_cnt;
  int   attempt_q[$];   // frames of the press currently being debounced
  bit   down;           // a press has been accepted and not yet released
  int   quiet;          // empty frames seen since the key went down
  ev_t  pend_q[$];
  bit   rand_ready = 0;
  logic [3:0] exp_kp;
  logic       exp_rd, exp_eq, exp_drop;
  logic [2:0] exp_op;

  int n_rd, n_op, n_eq, n_drop, rd_val, op_val, rd_edge, op_edge, eq_edge, drop_edge;

  function automatic ev_t key_event(input int k);
    ev_t e;
    e.kind = 0; e.val = 0;
    if (digit_of[k] >= 0) begin e.kind = 1; e.val = digit_of[k]; end
    else if (op_of[k] != 0) begin e.kind = 2; e.val = op_of[k]; end
    else if (k == 14) e.kind = 3;
    return e;
  endfunction

  task automatic model_frame(input logic [15:0] m, output bit acc, output ev_t ev);
    int  low;
    bit  chord;
    low = -1;
    for (int i = 15; i >= 0; i--) if (m[i]) low = i;
`ifdef KEYPAD_MULTIKEY_REJECT_EN
    chord = ($countones(m) > 1);
`else
    chord = 1'b0;
`endif
    acc = 0; ev.kind = 0; ev.val = 0;
    if (!down) begin
      if (low < 0 || chord) attempt_q.delete();
      else if (attempt_q.size() > 0 && attempt_q[0] != low) attempt_q.delete();
      else begin
        attempt_q.push_back(low);
        if (attempt_q.size() == DB) begin
          down = 1; quiet = 0; attempt_q.delete();
          ev  = key_event(low);
          acc = (ev.kind != 0);
        end
      end
    end else begin
      if (low < 0) begin
        quiet++;
        if (quiet == DB) down = 0;
      end else quiet = 0;
    end
  endtask

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // One clock: update the model at the edge, compare at the falling edge.
  task automatic cycle();
    bit   issue, acc;
    ev_t  ev, out;
    logic [3:0] exp_row;
    int   ri;
    @(posedge clk);
    edge_cnt++;
    issue = (pend_q.size() > 0) && (ready == 1'b1);
    exp_rd = 0; exp_op = 0; exp_eq = 0; exp_drop = 0;
    if (issue) begin
      out = pend_q.pop_front();
      case (out.kind)
        1: begin exp_rd = 1; exp_kp = 4'(out.val); end
        2: exp_op = 3'(out.val);
        3: exp_eq = 1;
        default: ;
      endcase
    end
    if (edge_cnt % FRAME == 0) begin
      model_frame(key_mask, acc, ev);
      if (acc) begin
        if (pend_q.size() == 0) pend_q.push_back(ev);
        else exp_drop = 1;
      end
    end
    @(negedge clk);
    ri = (edge_cnt / SD) % 4;
    exp_row = 4'hF;
    exp_row[ri] = 1'b0;
    total++;
    if ({row_out, keypad_input, read_input, operator_input, equal_input, key_dropped} !==
        {exp_row, exp_kp, exp_rd, exp_op, exp_eq, exp_drop}) begin
      bad++;
      $display("FAIL cycle %0d: got row=%b kp=%0d rd=%b op=%0d eq=%b drop=%b, want row=%b kp=%0d rd=%b op=%0d eq=%b drop=%b",
               edge_cnt, row_out, keypad_input, read_input, operator_input, equal_input, key_dropped,
               exp_row, exp_kp, exp_rd, exp_op, exp_eq, exp_drop);
    end
    if (read_input) begin
      n_rd++; rd_val = keypad_input; rd_edge = edge_cnt;
      $display("edge %0d: digit %0d", edge_cnt, keypad_input);
    end
    if (operator_input != 0) begin
      n_op++; op_val = operator_input; op_edge = edge_cnt;
      $display("edge %0d: operator %0d", edge_cnt, operator_input);
    end
    if (equal_input) begin
      n_eq++; eq_edge = edge_cnt;
      $display("edge %0d: equal", edge_cnt);
    end
    if (key_dropped) begin
      n_drop++; drop_edge = edge_cnt;
      $display("edge %0d: key dropped", edge_cnt);
    end
    if (rand_ready) ready = 1'($urandom_range(0, 1));
  endtask

  task automatic clear_obs();
    n_rd = 0; n_op = 0; n_eq = 0; n_drop = 0;
    rd_val = -1; op_val = -1; rd_edge = -1; op_edge = -1; eq_edge = -1; drop_edge = -1;
  endtask

  // Hold a key mask for n whole frames; call only right after a frame end.
  task automatic frames(input logic [15:0] m, input int n);
    key_mask = m;
    repeat (n * FRAME) cycle();
  endtask

  // Asynchronous reset, checked before any clock edge can act.
  task automatic do_reset(input string tag);
    nRST = 1'b0;
    key_mask = 16'h0;
    #1;
    check({tag, "_rst_row"}, int'(row_out), 4'b1110);
    check({tag, "_rst_outs"},
          int'({keypad_input, read_input, operator_input, equal_input, key_dropped}), 0);
    @(negedge clk);
    @(negedge clk);
    nRST = 1'b1;
    edge_cnt = 0;
    attempt_q.delete(); pend_q.delete(); down = 0; quiet = 0;
    exp_kp = 0; exp_rd = 0; exp_op = 0; exp_eq = 0; exp_drop = 0;
    clear_obs();
  endtask

  function automatic int obs_kind();
    if (n_rd + n_op + n_eq == 0) return 0;
    if (n_rd == 1 && n_op == 0 && n_eq == 0) return 1;
    if (n_op == 1 && n_rd == 0 && n_eq == 0) return 2;
    if (n_eq == 1 && n_rd == 0 && n_op == 0) return 3;
    return 9;
  endfunction

  typedef struct { int key; int kind; int val; } vec_t;
  vec_t vecs [16];

  initial begin
    vecs[0]  = '{0, 1, 1};  vecs[1]  = '{1, 1, 2};  vecs[2]  = '{2, 1, 3};  vecs[3]  = '{3, 2, 2};
    vecs[4]  = '{4, 1, 4};  vecs[5]  = '{5, 1, 5};  vecs[6]  = '{6, 1, 6};  vecs[7]  = '{7, 2, 3};
    vecs[8]  = '{8, 1, 7};  vecs[9]  = '{9, 1, 8};  vecs[10] = '{10, 1, 9}; vecs[11] = '{11, 2, 4};
    vecs[12] = '{12, 2, 1}; vecs[13] = '{13, 1, 0}; vecs[14] = '{14, 3, 0}; vecs[15] = '{15, 0, 0};

    // Single key held 4 frames: one digit 5, one cycle after the 2nd frame end.
    ready = 1'b1;
    do_reset("s1");
    frames(16'h1 << 5, 4);
    frames(16'h0, 3);
    check("s1_reads", n_rd, 1);
    check("s1_value", rd_val, 5);
    check("s1_edge", rd_edge, 2 * FRAME + 1);
    check("s1_hold", int'(keypad_input), 5);

    // MUL then EQUAL.
    do_reset("s2");
    frames(16'h1 << 11, 2);
    frames(16'h0, 2);
    frames(16'h1 << 14, 2);
    frames(16'h0, 2);
    check("s2_ops", n_op, 1);
    check("s2_opcode", op_val, 4);
    check("s2_op_edge", op_edge, 2 * FRAME + 1);
    check("s2_eqs", n_eq, 1);
    check("s2_eq_edge", eq_edge, 6 * FRAME + 1);
    check("s2_reads", n_rd, 0);

    // Bouncing key 7: only the stable pair of frames 3-4 counts.
    do_reset("s3");
    frames(16'h1 << 8, 1);
    frames(16'h0, 1);
    frames(16'h1 << 8, 2);
    frames(16'h0, 2);
    check("s3_reads", n_rd, 1);
    check("s3_value", rd_val, 7);
    check("s3_edge", rd_edge, 4 * FRAME + 1);

    // Controller busy: '3' waits in the buffer, '9' is dropped.
    ready = 1'b0;
    do_reset("s4");
    frames(16'h1 << 2, 2);
    frames(16'h0, 2);
    frames(16'h1 << 10, 2);
    frames(16'h0, 2);
    check("s4_busy_reads", n_rd, 0);
    check("s4_drops", n_drop, 1);
    check("s4_drop_edge", drop_edge, 6 * FRAME);
    ready = 1'b1;
    cycle();
    check("s4_late_reads", n_rd, 1);
    check("s4_late_value", rd_val, 3);
    check("s4_late_edge", rd_edge, 8 * FRAME + 1);
    repeat (FRAME - 1) cycle();

    // Chord of keys '1' and '2'.
    do_reset("s5");
    frames(16'h0003, 3);
    frames(16'h0, 2);
`ifdef KEYPAD_MULTIKEY_REJECT_EN
    check("s5_reads", n_rd, 0);
`else
    check("s5_reads", n_rd, 1);
    check("s5_value", rd_val, 1);
`endif

    // Reset with an event pending and a new press mid-debounce.
    ready = 1'b0;
    do_reset("s6a");
    frames(16'h1 << 5, 2);
    frames(16'h0, 2);
    frames(16'h1 << 4, 1);
    check("s6_pending_reads", n_rd, 0);
    ready = 1'b1;
    do_reset("s6b");
    frames(16'h0, 2);
    check("s6_after_reads", n_rd + n_op + n_eq + n_drop, 0);
    frames(16'h1 << 4, 2);
    frames(16'h0, 2);
    check("s6_new_reads", n_rd, 1);
    check("s6_new_value", rd_val, 4);

    // Every key once, against the constant key map.
    do_reset("tbl");
    for (int i = 0; i < 16; i++) begin
      clear_obs();
      frames(16'h1 << vecs[i].key, 2);
      frames(16'h0, 2);
      check($sformatf("tbl_kind_k%0d", vecs[i].key), obs_kind(), vecs[i].kind);
      check($sformatf("tbl_val_k%0d", vecs[i].key),
            (obs_kind() == 1) ? rd_val : (obs_kind() == 2) ? op_val : 0, vecs[i].val);
    end

    // Random presses, bounces, chords and back-pressure against the model.
    do_reset("rnd");
    rand_ready = 1;
    for (int s = 0; s < 80; s++) begin
      int sel;
      int nf;
      logic [15:0] m;
      sel = $urandom_range(0, 99);
      nf  = $urandom_range(1, 4);
      m   = 16'h0;
      if (sel >= 40 && sel < 85) m[$urandom_range(0, 15)] = 1'b1;
      else if (sel >= 85) begin
        m[$urandom_range(0, 15)] = 1'b1;
        m[$urandom_range(0, 15)] = 1'b1;
      end
      frames(m, nf);
    end
    rand_ready = 0;
    ready = 1'b1;
    frames(16'h0, 3);
    check("rnd_drained", pend_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
